addon_operand_recover: RTL and testbench
========================================

# addon_operand_recover

Sequential inverse of the addon tile's 3-bit carry-lookahead adder. Given the adder's 4-bit result `{Cout, Sum}`, one operand `A` and the carry-in, it recovers the other operand `B = result − A − Cin` with a bit-serial borrow chain. It also flags results that no legal `B` could produce. It sits beside the adder in the addon tile as its decode/check counterpart, behind a valid/ready handshake on both sides.

## Interface

Parameters:

- `WIDTH`, default 3: operand width. Result width is `WIDTH+1`; CALC takes `WIDTH+1` cycles.

Ports:

- `clk`  in  1  — single clock; all state changes on the rising edge.
- `rst`  in  1  — reset, synchronous, active-high.
- `in_valid`  in  1  — request carries a valid `result`/`a`/`cin`.
- `in_ready`  out  1  — block can accept a request; high only in IDLE.
- `result`  in  WIDTH+1  — adder output `{Cout, Sum}`.
- `a`  in  WIDTH  — known operand.
- `cin`  in  1  — carry-in used by the adder.
- `out_valid`  out  1  — `b`/`err` are valid; high only in DONE.
- `out_ready`  in  1  — consumer accepts the output.
- `b`  out  WIDTH  — recovered operand: low `WIDTH` bits of `(result − a − cin) mod 2^(WIDTH+1)`.
- `err`  out  1  — no legal `B` exists: the difference is negative (final borrow) or its MSB is 1 (greater than `2^WIDTH − 1`).

## Operation

- States are IDLE, CALC and DONE.
- **Reset.** State goes to IDLE. Bit index = 0, borrow = 0, difference register = 0. Outputs: `b` = 0, `err` = 0, `out_valid` = 0, `in_ready` = 1.
- **IDLE.**
  - `in_ready` = 1.
  - On an edge with `in_valid` = 1, the block accepts:
    - latches `result` into R and `{1'b0, a}` into X;
    - sets borrow = `cin` and index = 0;
    - moves to CALC.
  - Inputs are sampled only at the accept edge. Changes during CALC or DONE are ignored.
- **CALC.** One bit per edge, LSB first, for bit i = index:
  - `d[i] = R[i] ^ X[i] ^ borrow`
  - `borrow_next = (~R[i] & X[i]) | (~(R[i] ^ X[i]) & borrow)`
  - The index increments each edge. `in_valid` is ignored.
  - On the edge that processes i = `WIDTH`:
    - `b` ← `d[WIDTH-1:0]`;
    - `err` ← `d[WIDTH] | borrow_next`;
    - state → DONE.
- **DONE.**
  - `out_valid` = 1. `b` and `err` are held stable.
  - On an edge with `out_ready` = 1, state → IDLE and `out_valid` drops.
  - `b` and `err` keep their values in IDLE until the next completion overwrites them.
- All arithmetic is modulo `2^(WIDTH+1)`. No saturation.
- A mid-operation `rst` (in CALC or DONE) aborts the operation. No `out_valid` is produced, and all outputs return to their reset values on the next edge.
- Handshake rules:
  - Simultaneous `in_valid` and `out_ready` in DONE: only the output handshake happens. The input is not accepted until IDLE.
  - A request presented in CALC or DONE is not lost. It stays pending while `in_valid` holds and is accepted in IDLE.

## Timing

- The accept edge is E0. Bits 0..`WIDTH` are processed on edges E1..E(`WIDTH`+1).
- `out_valid` is high after E(`WIDTH`+1): latency is `WIDTH`+1 cycles (4 at default).
- Earliest output handshake is E(`WIDTH`+2). Back in IDLE, the earliest next accept is E(`WIDTH`+3).
- Maximum throughput is one operation per `WIDTH`+3 cycles (6 at default).
- `in_ready` and `out_valid` are decoded from the state register only. There is no combinational path from `in_valid`/`out_ready` to outputs.

## Test plan

- **Reset values.** Assert `rst` for 2 cycles → `in_ready` = 1, `out_valid` = 0, `b` = 0, `err` = 0.
- **Nominal.** `result` = 12, `a` = 5, `cin` = 1 → `out_valid` high exactly 4 cycles after accept, `b` = 6, `err` = 0. Hold `out_ready` = 0 for 3 cycles → `b` stays 6. Then `out_ready` = 1 → `in_ready` = 1 the next cycle.
- **Negative difference.** `result` = 3, `a` = 5, `cin` = 0 → `b` = 6 (from 14 mod 16), `err` = 1.
- **Overflow.** `result` = 15, `a` = 0, `cin` = 0 → `b` = 7, `err` = 1. Boundary: `result` = 15, `a` = 7, `cin` = 1 → `b` = 7, `err` = 0.
- **Exhaustive round-trip.** For all `A`, `B` in 0..7 and `cin` in 0..1, feed `result` = A+B+cin → `b` = B, `err` = 0. Drive `in_valid` continuously with random `out_ready` stalls; check no request is dropped or duplicated and throughput is at most 1 per 6 cycles.
- **Reset mid-operation.** Accept a request, assert `rst` at CALC cycle 2 → `out_valid` never rises, and the state is IDLE with reset outputs next cycle. Input changes during CALC do not alter the result.

Source files
------------

// File: rtl/addon_operand_recover.sv
// Bit-serial operand recovery for the addon carry-lookahead adder.
// Recovers b = result - a - cin over WIDTH+1 cycles and flags results no legal b can produce.
module addon_operand_recover #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   result,
    input  logic [WIDTH-1:0] a,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b,
    output logic             err
);
    localparam int unsigned IW = (WIDTH < 1) ? 1 : $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [WIDTH:0]   r;
    logic [WIDTH:0]   x;
    logic [WIDTH-1:0] diff;
    logic [IW-1:0]    idx;
    logic             borrow;
    logic             dbit;
    logic             bnext;

    // R and X shift right each step, so bit i always sits at position 0
    assign dbit  = r[0] ^ x[0] ^ borrow;
    assign bnext = (~r[0] & x[0]) | (~(r[0] ^ x[0]) & borrow);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            r      <= '0;
            x      <= '0;
            diff   <= '0;
            idx    <= '0;
            borrow <= 1'b0;
            b      <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        r      <= result;
                        x      <= {1'b0, a};
                        borrow <= cin;
                        idx    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    r      <= r >> 1;
                    x      <= x >> 1;
                    borrow <= bnext;
                    idx    <= idx + IW'(1);
                    // Difference bits enter at the top; after WIDTH steps diff holds d[WIDTH-1:0]
                    diff   <= WIDTH'({dbit, diff} >> 1);
                    if (idx == IW'(WIDTH)) begin
                        b     <= diff;
                        err   <= dbit | bnext;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_addon_operand_recover.sv
// Self-checking bench for addon_operand_recover: vector table, hand sequences and
// an exhaustive round-trip, with expected results queued at accept and checked at output.
module tb_addon_operand_recover;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] result = '0;
    logic [2:0] a = '0;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] b;
    logic       err;

    addon_operand_recover #(.WIDTH(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .a(a), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .b(b), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] res;
        logic [2:0] av;
        logic       ci;
        logic [2:0] eb;
        logic       ee;
    } vec_t;

    typedef struct {
        logic [2:0] b;
        logic       e;
    } exp_t;

    exp_t   exp_q[$];
    vec_t   vecs[8];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     last_acc = -1;
    int     n_push = 0;
    int     n_pop = 0;
    bit     ready_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        if (ready_mode) out_ready = 1'($urandom_range(0, 1));
    end

    // Output scoreboard and accept-spacing monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            last_acc = -1;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_output", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    n_pop++;
                    check("b", 32'(b), 32'(e.b));
                    check("err", 32'(err), 32'(e.e));
                end
            end
            if (in_valid && in_ready) begin
                if (last_acc >= 0) check("accept_gap_ok", 32'(cyc - last_acc >= 6), 1);
                last_acc = cyc;
            end
        end
    end

    task automatic send(input logic [3:0] res, input logic [2:0] av, input logic ci,
                        input logic [2:0] eb, input logic ee, input bit keep);
        bit ok;
        exp_t e;
        ok = 1'b0;
        result   = res;
        a        = av;
        cin      = ci;
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
        end else begin
            @(posedge clk);
            #1;
            e.b = eb;
            e.e = ee;
            exp_q.push_back(e);
            n_push++;
        end
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_done", 32'(ok), 1);
    endtask

    initial begin
        vecs[0] = '{res: 4'd3,  av: 3'd5, ci: 1'b0, eb: 3'd6, ee: 1'b1};
        vecs[1] = '{res: 4'd15, av: 3'd0, ci: 1'b0, eb: 3'd7, ee: 1'b1};
        vecs[2] = '{res: 4'd15, av: 3'd7, ci: 1'b1, eb: 3'd7, ee: 1'b0};
        vecs[3] = '{res: 4'd0,  av: 3'd0, ci: 1'b0, eb: 3'd0, ee: 1'b0};
        vecs[4] = '{res: 4'd0,  av: 3'd0, ci: 1'b1, eb: 3'd7, ee: 1'b1};
        vecs[5] = '{res: 4'd8,  av: 3'd0, ci: 1'b0, eb: 3'd0, ee: 1'b1};
        vecs[6] = '{res: 4'd7,  av: 3'd0, ci: 1'b0, eb: 3'd7, ee: 1'b0};
        vecs[7] = '{res: 4'd9,  av: 3'd3, ci: 1'b1, eb: 3'd5, ee: 1'b0};

        // Reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_b", 32'(b), 0);
        check("rst_err", 32'(err), 0);
        rst = 1'b0;

        // Nominal: latency, hold under stall, release
        out_ready = 1'b0;
        send(4'd12, 3'd5, 1'b1, 3'd6, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("nom_not_early", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        check("nom_latency", 32'(out_valid), 1);
        check("nom_b_direct", 32'(b), 6);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("nom_hold_valid", 32'(out_valid), 1);
            check("nom_hold_b", 32'(b), 6);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("nom_back_idle", 32'(in_ready), 1);
        check("nom_valid_drop", 32'(out_valid), 0);

        // Vector table
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].res, vecs[i].av, vecs[i].ci, vecs[i].eb, vecs[i].ee, 1'b0);
        end
        drain();

        // Exhaustive round-trip with continuous in_valid and random stalls
        ready_mode = 1'b1;
        for (int av = 0; av < 8; av++)
            for (int bv = 0; bv < 8; bv++)
                for (int ci = 0; ci < 2; ci++)
                    send(4'(av + bv + ci), 3'(av), 1'(ci), 3'(bv), 1'b0, 1'b1);
        in_valid = 1'b0;
        drain();
        ready_mode = 1'b0;
        #1;
        out_ready = 1'b0;

        // Reset in the middle of CALC
        check("mid_pre_b_nonzero", 32'(b != 3'd0), 1);
        result   = 4'd12;
        a        = 3'd5;
        cin      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("mid_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        result   = 4'd0;
        a        = 3'd7;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_in_ready", 32'(in_ready), 1);
        check("mid_out_valid", 32'(out_valid), 0);
        check("mid_b", 32'(b), 0);
        check("mid_err", 32'(err), 0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("mid_no_valid", 32'(out_valid), 0);
        end

        // Recovers cleanly after the abort
        out_ready = 1'b1;
        send(4'd15, 3'd7, 1'b1, 3'd7, 1'b0, 1'b0);
        drain();

        check("count_match", 32'(n_pop), 32'(n_push));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
